// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response bundle between a requester and muldiv_unit
//
// Signals:
//   req_valid  requester -> unit   operation presented
//   req_ready  unit -> requester   unit can accept this cycle (IDLE only)
//   a, b       requester -> unit   32-bit operands rs1 / rs2
//   funct3     requester -> unit   op select (MUL..REMU)
//   resp_valid unit -> requester   result is valid (DONE only)
//   resp_ready requester -> unit   consumer accepts the result
//   result     unit -> requester   32-bit result
//   busy       unit -> requester   unit is not IDLE
interface muldiv_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] result;
    logic        busy;

    modport master (
        output req_valid, a, b, funct3, resp_ready,
        input  req_ready, resp_valid, result, busy
    );

    modport slave (
        input  req_valid, a, b, funct3, resp_ready,
        output req_ready, resp_valid, result, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with fixed 33-cycle latency
//
// Ports:
//   clk  system clock, all state updates on the rising edge
//   rst  synchronous active-high reset
//   bus  muldiv_unit_if.slave request/response bundle
//
// Operation: an accepted request spends one setup cycle converting operands to
// magnitudes, then 32 one-bit iterations (shift-add multiply or restoring
// divide). The sign correction and special-case selection happen on the last
// iteration edge, so every operand pattern takes the same 33 cycles.
module muldiv_unit (
    input  logic           clk,
    input  logic           rst,
    muldiv_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_op;
    logic [4:0]  r_cnt;
    logic        r_setup;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_mb;
    logic        r_negq;
    logic        r_negr;
    logic [31:0] r_result;

    // Operand signedness per op: multiplies 00/01/10 have signed a, 00/01 signed b;
    // divides are signed when funct3[0] is clear.
    logic        w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag;

    assign w_a_signed = r_op[2] ? ~r_op[0] : (r_op[1:0] != 2'b11);
    assign w_b_signed = r_op[2] ? ~r_op[0] : ~r_op[1];
    assign w_a_neg    = w_a_signed & r_a[31];
    assign w_b_neg    = w_b_signed & r_b[31];
    assign w_a_mag    = w_a_neg ? (32'd0 - r_a) : r_a;
    assign w_b_mag    = w_b_neg ? (32'd0 - r_b) : r_b;

    // One iteration step. Multiply: {r_hi,r_lo} is the partial product with the
    // multiplier shifting out of r_lo. Divide: r_hi is the partial remainder and
    // r_lo shifts the dividend out while the quotient shifts in.
    logic [32:0] w_madd;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [31:0] w_step_hi, w_step_lo;

    assign w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mb} : 33'd0);
    assign w_shift = {r_hi, r_lo[31]};
    assign w_ge    = (w_shift >= {1'b0, r_mb});
    // When w_ge holds the difference is below the divisor, so 32 bits suffice.
    assign w_sub   = w_shift[31:0] - r_mb;

    always_comb begin
        w_step_hi = r_hi;
        w_step_lo = r_lo;
        if (r_op[2]) begin
            w_step_hi = w_ge ? w_sub : w_shift[31:0];
            w_step_lo = {r_lo[30:0], w_ge};
        end else begin
            w_step_hi = w_madd[32:1];
            w_step_lo = {w_madd[0], r_lo[31:1]};
        end
    end

    // Final selection, valid on the last iteration edge.
    logic [63:0] w_prod, w_prod_s;
    logic [31:0] w_quo, w_rem, w_final;
    logic        w_b_zero;

    assign w_prod   = {w_step_hi, w_step_lo};
    assign w_prod_s = r_negq ? (64'd0 - w_prod) : w_prod;
    assign w_quo    = r_negq ? (32'd0 - w_step_lo) : w_step_lo;
    assign w_rem    = r_negr ? (32'd0 - w_step_hi) : w_step_hi;
    assign w_b_zero = (r_b == 32'd0);

    always_comb begin
        w_final = 32'd0;
        case (r_op)
            3'b000:                 w_final = w_prod_s[31:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_s[63:32];
            3'b100, 3'b101:         w_final = w_b_zero ? 32'hFFFF_FFFF : w_quo;
            default:                w_final = w_b_zero ? r_a : w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid) w_next = CALC;
            CALC:    if (!r_setup && r_cnt == 5'd31) w_next = DONE;
            DONE:    if (bus.resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_op     <= 3'd0;
            r_cnt    <= 5'd0;
            r_setup  <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_mb     <= 32'd0;
            r_negq   <= 1'b0;
            r_negr   <= 1'b0;
            r_result <= 32'd0;
        end else begin
            case (r_state)
                IDLE: if (bus.req_valid) begin
                    r_a     <= bus.a;
                    r_b     <= bus.b;
                    r_op    <= bus.funct3;
                    r_cnt   <= 5'd0;
                    r_setup <= 1'b1;
                end
                CALC: if (r_setup) begin
                    r_setup <= 1'b0;
                    r_hi    <= 32'd0;
                    r_lo    <= w_a_mag;
                    r_mb    <= w_b_mag;
                    r_negq  <= w_a_neg ^ w_b_neg;
                    r_negr  <= w_a_neg;
                end else begin
                    r_hi  <= w_step_hi;
                    r_lo  <= w_step_lo;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) r_result <= w_final;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = (r_state == DONE);
    assign bus.busy       = (r_state != IDLE);
    assign bus.result     = r_result;
endmodule
